// File: rtl/uart_rx_frontend.sv
// 8N1 serial receive front end with a valid/ready holding register.
// The rx pin is synchronised; all other logic runs in the clk domain.
`default_nettype none

module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic                 tick;
    logic                 byte_done;
    logic                 frame_bad;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;

    // Synchroniser idles high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fall) state_next = START;
            end
            START: begin
                if (tick) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && bit_idx == LAST_BIT) state_next = STOP;
            end
            STOP: begin
                if (tick) state_next = IDLE;
            end
        endcase
        if (!ena) state_next = IDLE;
    end

    always_comb begin
        tick = 1'b0;
        busy = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            START: begin
                busy = 1'b1;
                tick = (cnt == HALF_LAST);
            end
            DATA, STOP: begin
                busy = 1'b1;
                tick = (cnt == FULL_LAST);
            end
        endcase
    end

    assign byte_done = ena && state == STOP && tick && rx_s;
    assign frame_bad = ena && state == STOP && tick && !rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (!ena) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                end
                START: begin
                    cnt     <= tick ? '0 : cnt + 1'b1;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                end
            endcase
        end
    end

    // A draining handshake on the completion edge frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 16 clocks per bit.
// Flag pulses and delivered bytes are recorded on the falling clock edge.
`timescale 1ns/1ps

module tb_uart_rx_frontend;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_start = 0;
    int         rise_cyc = 0;
    int         fe_cycles = 0;
    int         ov_cycles = 0;
    int         lat = 0;
    int         lat_use = 155;
    int         fe0;
    int         ov0;
    logic       valid_q = 1'b0;
    logic [7:0] q[$];

    uart_rx_frontend #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cycles++;
        if (overrun) ov_cycles++;
        if (data_valid && !valid_q) rise_cyc = cyc;
        valid_q = data_valid;
        if (data_valid && data_ready) q.push_back(data_out);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is always 1ns after an edge, so frames chain without gaps.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            cycles(16);
        end
        rx = 1'b1;
    endtask

    function automatic logic [31:0] qat(input int i);
        if (i < q.size()) return 32'(q[i]);
        return 32'hFFFF;
    endfunction

    initial begin
        cycles(4);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cycles(5);

        // 1: single frame, held until handshake
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - last_start;
        check("t1_latency_ok", 32'(lat >= 152 && lat <= 156), 32'd1);
        if (lat >= 152 && lat <= 156) lat_use = lat;
        check("t1_valid", 32'(data_valid), 32'd1);
        check("t1_data", 32'(data_out), 32'hA5);
        cycles(20);
        check("t1_held", 32'(data_out), 32'hA5);
        check("t1_held_valid", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;
        check("t1_valid_clr", 32'(data_valid), 32'd0);
        check("t1_taken", qat(0), 32'hA5);
        q.delete();
        cycles(5);

        // 2: start glitch
        fe0 = fe_cycles;
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(16);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_valid", 32'(data_valid), 32'd0);
        check("t2_ferr", 32'(fe_cycles - fe0), 32'd0);

        // 3: framing error
        fe0 = fe_cycles;
        send_frame(8'h3C, 1'b0);
        cycles(8);
        check("t3_ferr_cycles", 32'(fe_cycles - fe0), 32'd1);
        check("t3_valid", 32'(data_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // 4a: overrun with back-to-back frames
        ov0 = ov_cycles;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cycles(4);
        check("t4a_ovr_cycles", 32'(ov_cycles - ov0), 32'd1);
        check("t4a_data", 32'(data_out), 32'h11);
        check("t4a_valid", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;

        // 4b: drain on the completion edge
        send_frame(8'h11, 1'b1);
        ov0 = ov_cycles;
        fork
            send_frame(8'h22, 1'b1);
            begin
                cycles(lat_use - 1);
                data_ready = 1'b1;
                cycles(1);
                data_ready = 1'b0;
            end
        join
        cycles(4);
        check("t4b_data", 32'(data_out), 32'h22);
        check("t4b_valid", 32'(data_valid), 32'd1);
        check("t4b_ovr", 32'(ov_cycles - ov0), 32'd0);
        check("t4b_drained", qat(1), 32'h11);
        data_ready = 1'b1;
        cycles(1);
        q.delete();

        // 5: back-to-back stream, ready held high
        fe0 = fe_cycles;
        ov0 = ov_cycles;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        cycles(20);
        check("t5_count", 32'(q.size()), 32'd3);
        check("t5_b0", qat(0), 32'h00);
        check("t5_b1", qat(1), 32'hFF);
        check("t5_b2", qat(2), 32'h81);
        check("t5_flags", 32'((fe_cycles - fe0) + (ov_cycles - ov0)), 32'd0);
        q.delete();

        // 6a: enable dropped mid-data
        fork
            send_frame(8'h55, 1'b1);
            begin
                cycles(60);
                check("t6a_busy_pre", 32'(busy), 32'd1);
                ena = 1'b0;
                cycles(1);
                check("t6a_busy_off", 32'(busy), 32'd0);
            end
        join
        ena = 1'b1;
        cycles(5);
        check("t6a_no_byte", 32'(q.size()), 32'd0);
        send_frame(8'h5A, 1'b1);
        cycles(20);
        check("t6a_after", qat(0), 32'h5A);
        check("t6a_after_cnt", 32'(q.size()), 32'd1);

        // 6b: reset mid-frame with a pending byte
        data_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        check("t6b_pending", 32'(data_valid), 32'd1);
        fork
            send_frame(8'h33, 1'b1);
            begin
                cycles(80);
                rst_n = 1'b0;
                cycles(1);
                check("t6b_data", 32'(data_out), 32'h0);
                check("t6b_valid", 32'(data_valid), 32'd0);
                check("t6b_busy", 32'(busy), 32'd0);
                check("t6b_ferr", 32'(frame_err), 32'd0);
                check("t6b_ovr", 32'(overrun), 32'd0);
                rst_n = 1'b1;
            end
        join
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
